// File: rtl/ld_pkg.sv
// Shared types for the linked-data slot allocator.
package ld_pkg;

  // Slot-search policy used when picking a free slot to grant.
  typedef enum logic [0:0] {
    LOWEST_FIRST = 1'b0,
    ROUND_ROBIN  = 1'b1
  } ld_alloc_mode_e;

endpackage

// File: rtl/ld_alloc_if.sv
// Bundle of the allocator's request/grant, release and status signals.
//
// Handshake semantics:
//   alloc_req is a level request. alloc_gnt answers in the same cycle
//   (combinational), and a slot is consumed on every rising edge where
//   alloc_req & alloc_gnt is 1. A requester may drop alloc_req at any time.
//   release_valid has no ready: it is a one-cycle command that takes effect
//   on the rising edge where it is 1. flush likewise takes effect on the edge.
interface ld_alloc_if #(
  parameter int unsigned MaxTxns  = 16,
  parameter int unsigned IdxWidth = $clog2(MaxTxns)
);
  logic                alloc_req;
  logic                alloc_gnt;
  logic [IdxWidth-1:0] alloc_idx;
  logic                release_valid;
  logic [IdxWidth-1:0] release_idx;
  logic                flush;
  logic [MaxTxns-1:0]  free_mask;
  logic [IdxWidth:0]   occupancy;
  logic                full;
  logic                empty;
  logic                err;

  // The requester side: drives commands, observes grants and status.
  modport master (
    output alloc_req, release_valid, release_idx, flush,
    input  alloc_gnt, alloc_idx, free_mask, occupancy, full, empty, err
  );

  // The allocator side.
  modport slave (
    input  alloc_req, release_valid, release_idx, flush,
    output alloc_gnt, alloc_idx, free_mask, occupancy, full, empty, err
  );
endinterface

// File: rtl/ld_free_finder.sv
// Finds the first set bit of a free mask at or above a start index,
// wrapping from MaxTxns-1 back to 0.
module ld_free_finder #(
  parameter int unsigned MaxTxns  = 16,
  parameter int unsigned IdxWidth = $clog2(MaxTxns)
) (
  input  logic [MaxTxns-1:0]  free_mask_i,
  input  logic [IdxWidth-1:0] start_i,
  output logic                found_o,
  output logic [IdxWidth-1:0] idx_o
);

  // Scan from farthest to nearest so the last hit written is the nearest one.
  always_comb begin
    int                  j;
    logic [IdxWidth-1:0] jj;
    j       = 0;
    jj      = '0;
    found_o = 1'b0;
    idx_o   = '0;
    for (int k = int'(MaxTxns) - 1; k >= 0; k--) begin
      j = int'(start_i) + k;
      if (j >= int'(MaxTxns)) begin
        j = j - int'(MaxTxns);
      end
      jj = IdxWidth'(j);
      if (free_mask_i[jj]) begin
        found_o = 1'b1;
        idx_o   = jj;
      end
    end
  end

endmodule

// File: rtl/ld_alloc.sv
// Linked-data slot allocator: grants one free slot per cycle, accepts one
// release per cycle, tracks occupancy and flags illegal releases.
module ld_alloc
  import ld_pkg::*;
#(
  parameter int unsigned    MaxTxns   = 16,
  parameter ld_alloc_mode_e AllocMode = LOWEST_FIRST,
  parameter int unsigned    IdxWidth  = $clog2(MaxTxns)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                alloc_req_i,
  output logic                alloc_gnt_o,
  output logic [IdxWidth-1:0] alloc_idx_o,
  input  logic                release_valid_i,
  input  logic [IdxWidth-1:0] release_idx_i,
  input  logic                flush_i,
  output logic [MaxTxns-1:0]  free_mask_o,
  output logic [IdxWidth:0]   occupancy_o,
  output logic                full_o,
  output logic                empty_o,
  output logic                err_o
);

  localparam logic [MaxTxns-1:0]  AllFree = {MaxTxns{1'b1}};
  localparam logic [IdxWidth:0]   OccMax  = (IdxWidth + 1)'(MaxTxns);
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(MaxTxns - 1);

  logic [MaxTxns-1:0]  free_mask_q, free_mask_d;
  logic [IdxWidth:0]   occ_q, occ_d;
  logic [IdxWidth-1:0] ptr_q, ptr_d;
  logic                err_q, err_d;

  logic [IdxWidth-1:0] search_start;
  logic                found;
  logic [IdxWidth-1:0] found_idx;
  logic                gnt;
  logic                rel_in_range;
  logic                rel_legal;

  // Lowest-first always searches from slot 0; round-robin resumes after the
  // last granted slot.
  assign search_start = (AllocMode == ROUND_ROBIN) ? ptr_q : '0;

  ld_free_finder #(
    .MaxTxns  (MaxTxns),
    .IdxWidth (IdxWidth)
  ) u_finder (
    .free_mask_i (free_mask_q),
    .start_i     (search_start),
    .found_o     (found),
    .idx_o       (found_idx)
  );

  // Index range check is only meaningful when MaxTxns is not a power of two.
  if (MaxTxns == (32'd1 << IdxWidth)) begin : g_pow2
    assign rel_in_range = 1'b1;
  end else begin : g_npow2
    assign rel_in_range = (32'(release_idx_i) < 32'(MaxTxns));
  end

  // A release is legal only for an in-range slot that is currently busy.
  assign rel_legal = release_valid_i & rel_in_range & ~free_mask_q[release_idx_i];

  // Grant uses only the registered mask, so a same-cycle release never bypasses.
  assign gnt = alloc_req_i & ~flush_i & ~rst_i & found;

  // Next-state: flush wins, otherwise apply grant and legal release together.
  always_comb begin
    free_mask_d = free_mask_q;
    occ_d       = occ_q;
    ptr_d       = ptr_q;
    err_d       = 1'b0;
    if (flush_i) begin
      free_mask_d = AllFree;
      occ_d       = '0;
      ptr_d       = '0;
      err_d       = 1'b0;
    end else begin
      if (gnt) begin
        free_mask_d[found_idx] = 1'b0;
        ptr_d = (found_idx == LastIdx) ? '0 : found_idx + 1'b1;
      end
      if (rel_legal) begin
        free_mask_d[release_idx_i] = 1'b1;
      end
      occ_d = occ_q + (IdxWidth + 1)'(gnt) - (IdxWidth + 1)'(rel_legal);
      err_d = release_valid_i & ~rel_legal;
    end
  end

  // State registers; reset frees every slot immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      free_mask_q <= AllFree;
      occ_q       <= '0;
      ptr_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      free_mask_q <= free_mask_d;
      occ_q       <= occ_d;
      ptr_q       <= ptr_d;
      err_q       <= err_d;
    end
  end

  assign alloc_gnt_o = gnt;
  assign alloc_idx_o = found_idx;
  assign free_mask_o = free_mask_q;
  assign occupancy_o = occ_q;
  assign full_o      = (occ_q == OccMax);
  assign empty_o     = (occ_q == '0);
  assign err_o       = err_q;

endmodule

// File: tb/tb_ld_alloc.sv
// Directed bench for ld_alloc: lowest-first and round-robin 16-slot builds,
// plus a 17-slot build for out-of-range release indices.
module tb_ld_alloc;
  import ld_pkg::*;

  logic clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];

  ld_alloc_if #(.MaxTxns(16)) lf_if ();
  ld_alloc_if #(.MaxTxns(16)) rr_if ();
  ld_alloc_if #(.MaxTxns(17)) x_if ();

  ld_alloc #(.MaxTxns(16), .AllocMode(LOWEST_FIRST)) u_lf (
    .clk_i (clk), .rst_i (rst),
    .alloc_req_i (lf_if.alloc_req), .alloc_gnt_o (lf_if.alloc_gnt),
    .alloc_idx_o (lf_if.alloc_idx), .release_valid_i (lf_if.release_valid),
    .release_idx_i (lf_if.release_idx), .flush_i (lf_if.flush),
    .free_mask_o (lf_if.free_mask), .occupancy_o (lf_if.occupancy),
    .full_o (lf_if.full), .empty_o (lf_if.empty), .err_o (lf_if.err)
  );

  ld_alloc #(.MaxTxns(16), .AllocMode(ROUND_ROBIN)) u_rr (
    .clk_i (clk), .rst_i (rst),
    .alloc_req_i (rr_if.alloc_req), .alloc_gnt_o (rr_if.alloc_gnt),
    .alloc_idx_o (rr_if.alloc_idx), .release_valid_i (rr_if.release_valid),
    .release_idx_i (rr_if.release_idx), .flush_i (rr_if.flush),
    .free_mask_o (rr_if.free_mask), .occupancy_o (rr_if.occupancy),
    .full_o (rr_if.full), .empty_o (rr_if.empty), .err_o (rr_if.err)
  );

  ld_alloc #(.MaxTxns(17), .AllocMode(LOWEST_FIRST)) u_x (
    .clk_i (clk), .rst_i (rst),
    .alloc_req_i (x_if.alloc_req), .alloc_gnt_o (x_if.alloc_gnt),
    .alloc_idx_o (x_if.alloc_idx), .release_valid_i (x_if.release_valid),
    .release_idx_i (x_if.release_idx), .flush_i (x_if.flush),
    .free_mask_o (x_if.free_mask), .occupancy_o (x_if.occupancy),
    .full_o (x_if.full), .empty_o (x_if.empty), .err_o (x_if.err)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: a queued entry means a grant with that index is expected now.
  task automatic sb_grant(input string tag, input logic gnt, input logic [31:0] idx);
    logic [31:0] e;
    if (exp_q.size() > 0) begin
      e = 32'(exp_q.pop_front());
      chk({tag, "_gnt"}, 32'(gnt), 32'd1);
      if (gnt === 1'b1) chk({tag, "_idx"}, idx, e);
    end else begin
      chk({tag, "_gnt"}, 32'(gnt), 32'd0);
    end
  endtask

  // One cycle on the lowest-first build: drive, check grant, advance past the edge.
  task automatic lf_step(input string tag, input logic req, input logic rel,
                         input logic [3:0] ridx, input logic fl);
    @(negedge clk);
    lf_if.alloc_req = req; lf_if.release_valid = rel;
    lf_if.release_idx = ridx; lf_if.flush = fl;
    #1;
    sb_grant(tag, lf_if.alloc_gnt, 32'(lf_if.alloc_idx));
    @(posedge clk);
    #1;
  endtask

  task automatic rr_step(input string tag, input logic req, input logic rel,
                         input logic [3:0] ridx);
    @(negedge clk);
    rr_if.alloc_req = req; rr_if.release_valid = rel;
    rr_if.release_idx = ridx; rr_if.flush = 1'b0;
    #1;
    sb_grant(tag, rr_if.alloc_gnt, 32'(rr_if.alloc_idx));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    lf_if.alloc_req = 1'b1; lf_if.release_valid = 1'b0; lf_if.release_idx = '0; lf_if.flush = 1'b0;
    rr_if.alloc_req = 1'b0; rr_if.release_valid = 1'b0; rr_if.release_idx = '0; rr_if.flush = 1'b0;
    x_if.alloc_req = 1'b0; x_if.release_valid = 1'b0; x_if.release_idx = '0; x_if.flush = 1'b0;

    // Reset values, with a request pending
    #2;
    chk("rst_mask", 32'(lf_if.free_mask), 32'hffff);
    chk("rst_occ", 32'(lf_if.occupancy), 32'd0);
    chk("rst_empty", 32'(lf_if.empty), 32'd1);
    chk("rst_full", 32'(lf_if.full), 32'd0);
    chk("rst_err", 32'(lf_if.err), 32'd0);
    chk("rst_gnt", 32'(lf_if.alloc_gnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    lf_if.alloc_req = 1'b0;

    // Fill the lowest-first table in index order
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'(i));
      lf_step("fill", 1'b1, 1'b0, 4'd0, 1'b0);
      chk("fill_occ", 32'(lf_if.occupancy), 32'(i + 1));
    end
    chk("fill_full", 32'(lf_if.full), 32'd1);
    chk("fill_mask", 32'(lf_if.free_mask), 32'h0);
    lf_step("req17", 1'b1, 1'b0, 4'd0, 1'b0);
    chk("req17_occ", 32'(lf_if.occupancy), 32'd16);

    // Release while full: no bypass, grant returns one cycle later
    lf_step("full_rel", 1'b1, 1'b1, 4'd5, 1'b0);
    chk("full_rel_mask", 32'(lf_if.free_mask), 32'h0020);
    chk("full_rel_occ", 32'(lf_if.occupancy), 32'd15);
    exp_q.push_back(8'd5);
    lf_step("regrant", 1'b1, 1'b0, 4'd0, 1'b0);
    chk("regrant_occ", 32'(lf_if.occupancy), 32'd16);
    chk("regrant_full", 32'(lf_if.full), 32'd1);

    // Legal release of 7, then release 7 again while it is free
    lf_step("rel7", 1'b0, 1'b1, 4'd7, 1'b0);
    chk("rel7_err", 32'(lf_if.err), 32'd0);
    chk("rel7_mask", 32'(lf_if.free_mask), 32'h0080);
    lf_step("rel7_again", 1'b0, 1'b1, 4'd7, 1'b0);
    chk("dbl_err", 32'(lf_if.err), 32'd1);
    chk("dbl_mask", 32'(lf_if.free_mask), 32'h0080);
    chk("dbl_occ", 32'(lf_if.occupancy), 32'd15);
    lf_step("idle", 1'b0, 1'b0, 4'd0, 1'b0);
    chk("dbl_err_pulse", 32'(lf_if.err), 32'd0);

    // Flush, build occupancy 9, then flush against a request and a legal release
    lf_step("flush0", 1'b0, 1'b0, 4'd0, 1'b1);
    chk("flush0_mask", 32'(lf_if.free_mask), 32'hffff);
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(8'(i));
      lf_step("fill9", 1'b1, 1'b0, 4'd0, 1'b0);
    end
    chk("fill9_occ", 32'(lf_if.occupancy), 32'd9);
    lf_step("flush", 1'b1, 1'b1, 4'd3, 1'b1);
    chk("flush_mask", 32'(lf_if.free_mask), 32'hffff);
    chk("flush_occ", 32'(lf_if.occupancy), 32'd0);
    chk("flush_empty", 32'(lf_if.empty), 32'd1);
    chk("flush_err", 32'(lf_if.err), 32'd0);

    // Asynchronous reset mid-cycle with occupancy 4
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'(i));
      lf_step("fill4", 1'b1, 1'b0, 4'd0, 1'b0);
    end
    chk("fill4_occ", 32'(lf_if.occupancy), 32'd4);
    @(negedge clk);
    lf_if.alloc_req = 1'b1; lf_if.release_valid = 1'b0; lf_if.flush = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_mask", 32'(lf_if.free_mask), 32'hffff);
    chk("arst_occ", 32'(lf_if.occupancy), 32'd0);
    chk("arst_empty", 32'(lf_if.empty), 32'd1);
    chk("arst_gnt", 32'(lf_if.alloc_gnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    lf_if.alloc_req = 1'b0;

    // Round-robin: 0,1,2; release 0; next grant is 3; wraps to 0 after 15
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'(i));
      rr_step("rr_fill", 1'b1, 1'b0, 4'd0);
    end
    rr_step("rr_rel0", 1'b0, 1'b1, 4'd0);
    chk("rr_rel0_mask", 32'(rr_if.free_mask), 32'hfff9);
    for (int i = 3; i < 16; i++) begin
      exp_q.push_back(8'(i));
      rr_step("rr_seq", 1'b1, 1'b0, 4'd0);
    end
    exp_q.push_back(8'd0);
    rr_step("rr_wrap", 1'b1, 1'b0, 4'd0);
    chk("rr_full", 32'(rr_if.full), 32'd1);
    chk("rr_occ", 32'(rr_if.occupancy), 32'd16);
    rr_step("rr_idle", 1'b0, 1'b0, 4'd0);

    // Out-of-range release on the 17-slot build
    @(negedge clk);
    x_if.release_valid = 1'b1; x_if.release_idx = 5'd20;
    #1;
    chk("oor_err_early", 32'(x_if.err), 32'd0);
    @(posedge clk);
    #1;
    chk("oor_err", 32'(x_if.err), 32'd1);
    chk("oor_mask", 32'(x_if.free_mask), 32'h1ffff);
    chk("oor_occ", 32'(x_if.occupancy), 32'd0);
    @(negedge clk);
    x_if.release_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("oor_err_pulse", 32'(x_if.err), 32'd0);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ld_alloc.md
LD_ALLOC -- requirements
Module: ld_alloc

Interface
REQ-001 SHALL have parameter MaxTxns, default 16: number of linked-data slots; legal range 2..256.
REQ-002 SHALL have parameter AllocMode, default LOWEST_FIRST: slot-search policy, LOWEST_FIRST or ROUND_ROBIN.
REQ-003 SHALL have parameter IdxWidth, default $clog2(MaxTxns): slot index width; not overridden by users.
REQ-004 SHALL have port clk_i, input, 1: single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_i, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port alloc_req_i, input, 1: request for one free slot.
REQ-007 SHALL have port alloc_gnt_o, output, 1: slot granted this cycle.
REQ-008 SHALL have port alloc_idx_o, output, IdxWidth: granted slot index; valid only while alloc_gnt_o=1.
REQ-009 SHALL have port release_valid_i, input, 1: release of one slot.
REQ-010 SHALL have port release_idx_i, input, IdxWidth: slot index being released.
REQ-011 SHALL have port flush_i, input, 1: free all slots synchronously.
REQ-012 SHALL have port free_mask_o, output, MaxTxns: registered per-slot free bits, 1 = free.
REQ-013 SHALL have port occupancy_o, output, IdxWidth+1: number of busy slots.
REQ-014 SHALL have ports full_o and empty_o, output, 1 each: occupancy_o==MaxTxns and occupancy_o==0.
REQ-015 SHALL have port err_o, output, 1: one-cycle pulse on illegal release.

Function
REQ-016 alloc_gnt_o SHALL be combinational: alloc_req_i & ~flush_i & (|free_mask_o); no requirement on alloc_req_i holding.
REQ-017 LOWEST_FIRST: alloc_idx_o SHALL be the lowest-index free slot of free_mask_o.
REQ-018 ROUND_ROBIN: alloc_idx_o SHALL be the first free slot at or above the round-robin pointer, wrapping past MaxTxns-1 to 0.
REQ-019 Round-robin pointer SHALL be set, at the granting edge, to granted index+1, wrapping from MaxTxns-1 to 0; unchanged otherwise.
REQ-020 On a grant, the granted slot's free bit SHALL clear at the next rising edge (latency 1).
REQ-021 A valid release SHALL set the slot's free bit at the next rising edge; a slot released in cycle N SHALL NOT be grantable before cycle N+1 (no bypass).
REQ-022 Release SHALL be illegal if release_idx_i>=MaxTxns or the slot is already free; an illegal release SHALL leave all state unchanged and pulse err_o for one cycle, registered, in the following cycle.
REQ-023 occupancy_o SHALL increment by 1 on grant only, decrement by 1 on legal release only, and stay unchanged on simultaneous grant and legal release.
REQ-024 When full_o=1, alloc_gnt_o SHALL be 0 even with a same-cycle release.
REQ-025 flush_i SHALL take priority over grant and release: next edge all free bits 1, occupancy 0, pointer 0, err_o 0.
REQ-026 occupancy_o SHALL always equal the number of zero bits in free_mask_o.

Reset
REQ-027 While rst_i=1: free_mask_o all ones, occupancy_o 0, empty_o 1, full_o 0, err_o 0, pointer 0; alloc_gnt_o SHALL be 0.
REQ-028 Reset asserted mid-operation SHALL discard all allocations immediately, without waiting for a clock edge.

Structure
REQ-029 Shared package ld_pkg SHALL hold enum ld_alloc_mode_e (LOWEST_FIRST, ROUND_ROBIN).
REQ-030 Free-slot search SHALL be a sub-module ld_free_finder (inputs: free mask, start index; outputs: found, index), used with start 0 in LOWEST_FIRST mode.
REQ-031 State SHALL be limited to free mask, occupancy counter, pointer and err register; outputs SHALL carry no combinational path from release_* inputs.

Verification
REQ-032 Reset, then alloc_req_i=1 for 16 cycles (MaxTxns=16, LOWEST_FIRST) -> idx 0..15 in order, full_o=1 after 16th edge, 17th request gnt=0.
REQ-033 Full table; release idx 5 together with alloc_req_i -> gnt=0 that cycle; next cycle gnt=1, idx=5, occupancy stays 16.
REQ-034 ROUND_ROBIN: allocate 0,1,2; release 0; request -> idx=3, not 0; after reaching 15, next grant wraps to 0.
REQ-035 Release idx 7 while free; separately release idx 20 with MaxTxns=16, IdxWidth=5 forced by MaxTxns=17 build -> err_o pulse one cycle later, mask and occupancy unchanged.
REQ-036 Occupancy 9, flush_i=1 with alloc_req_i=1 and a legal release -> gnt=0, next edge mask all ones, occupancy 0, empty_o=1.
REQ-037 rst_i asserted asynchronously mid-cycle with occupancy 4 -> outputs at reset values before the next clock edge.
